// File: rtl/sumador_serial_ctrl.sv
// ============================================================================
// sumador_serial_ctrl
// ----------------------------------------------------------------------------
// Bit-serial adder/subtractor controller for the ALU arithmetic path. A single
// sumador_1bit full adder is reused over N clock cycles, one bit per cycle,
// LSB first, to compute a+b+carry_in (op=0) or a-b (op=1, two's complement).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request; sampled only while IDLE
//   op           in   0 = add with carry_in, 1 = subtract (carry_in ignored)
//   a, b         in   N-bit operands, latched on an accepted start
//   carry_in     in   initial carry for add, latched on an accepted start
//   busy         out  high while the FSM is not IDLE
//   done         out  one-cycle pulse; sum/carry_out/overflow are valid
//   sum          out  N-bit result (partial contents visible during CALC)
//   carry_out    out  carry out of the MSB (for subtract: 1 = no borrow)
//   overflow     out  signed overflow (carry into MSB xor carry out of MSB)
//   o_dbg_state  out  current FSM state encoding (IDLE=0, CALC=1, FIN=2)
//
// Handshake: start is only looked at on a rising edge while IDLE. When it is
// accepted, busy rises, and exactly N edges later done is high for one cycle.
// start seen in CALC or FIN is dropped, never queued.
// ============================================================================

// ----------------------------------------------------------------------------
// sumador_1bit: combinational 1-bit full adder, the only arithmetic resource.
//   i_a, i_b, i_cin  in   addend bits and incoming carry
//   o_sum            out  sum bit
//   o_cout           out  carry out
// ----------------------------------------------------------------------------
module sumador_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module sumador_serial_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow,
    output logic [1:0]   o_dbg_state
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry_msb;

    logic             w_fa_sum;
    logic             w_fa_cout;

    // The full adder always looks at the bottom of the operand shift
    // registers and the running carry; only CALC consumes its outputs.
    sumador_1bit u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // Derived from the registered state so it drops immediately on reset.
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_carry_msb <= 1'b0;
            done        <= 1'b0;
            sum         <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a         <= a;
                        // Subtraction is a + ~b + 1: invert B once here and
                        // force the initial carry to 1.
                        r_b         <= op ? ~b : b;
                        r_carry     <= op ? 1'b1 : carry_in;
                        r_idx       <= '0;
                        r_carry_msb <= 1'b0;
                        sum         <= '0;
                        carry_out   <= 1'b0;
                        overflow    <= 1'b0;
                        r_state     <= CALC;
                    end
                end

                CALC: begin
                    // Result bits enter at the MSB and walk right, so after N
                    // shifts the first (LSB) result bit lands in sum[0].
                    sum     <= {w_fa_sum, sum[N-1:1]};
                    r_carry <= w_fa_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        // r_carry at this point is the carry into the MSB.
                        r_carry_msb <= r_carry;
                        carry_out   <= w_fa_cout;
                        overflow    <= r_carry ^ w_fa_cout;
                        r_idx       <= '0;
                        done        <= 1'b1;
                        r_state     <= FIN;
                    end
                end

                FIN: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
module tb_sumador_serial_ctrl;

    localparam int N = 4;

    logic         clk;
    logic         clk_en;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    sumador_serial_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done after the accepting edge; returns the number of edges
    // seen (bounded so a dead DUT cannot hang the run).
    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (done !== 1'b1 && edges < 20);
    endtask

    // Full operation: start pulsed for one edge, inputs scrambled afterwards,
    // then latency, result and post-done behaviour are checked.
    task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic top, input logic tcin, input logic [N-1:0] exp_sum,
                         input logic exp_co, input logic exp_ov);
        int edges;
        @(negedge clk);
        a = ta; b = tb; op = top; carry_in = tcin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = N'($urandom_range(0, 15));
        b = N'($urandom_range(0, 15));
        op = 1'($urandom_range(0, 1));
        carry_in = 1'($urandom_range(0, 1));
        chk({tag, "_busy_e0"}, busy, 1'b1);
        chk({tag, "_done_e0"}, done, 1'b0);
        wait_done(edges);
        chk({tag, "_latency"}, edges, N);
        chk({tag, "_state_fin"}, dbg_state, 2'd2);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, carry_out, exp_co);
        chk({tag, "_ovf"}, overflow, exp_ov);
        @(posedge clk);
        #1;
        chk({tag, "_done_clr"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_sum_hold"}, sum, exp_sum);
        chk({tag, "_cout_hold"}, carry_out, exp_co);
        chk({tag, "_ovf_hold"}, overflow, exp_ov);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int edges;
        int saw_done;
        clk_en = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        carry_in = 1'b0;

        // Asynchronous reset with the clock stopped.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 4'b0000);
        chk("rst_cout", carry_out, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        #5 rst_n = 1'b1;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);

        // Add, wrap and carry_in.
        do_op("add",  4'b0101, 4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
        do_op("wrap", 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        do_op("cin",  4'b0111, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1);

        // Subtract.
        do_op("sub1", 4'b0011, 4'b0101, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0);
        do_op("sub2", 4'b1000, 4'b0001, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b1);

        // Start while busy: second request held from before E2 through FIN.
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; op = 1'b0; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);                   // E0
        #1 start = 1'b0;
        @(posedge clk);                   // E1
        #1;
        a = 4'b1111; b = 4'b1111; start = 1'b1;
        wait_done(edges);
        chk("busy_latency", edges, N - 1);
        chk("busy_sum1", sum, 4'b0010);
        chk("busy_cout1", carry_out, 1'b0);
        @(posedge clk);                   // FIN -> IDLE, start not sampled
        #1;
        chk("busy_idle_gap", busy, 1'b0);
        chk("busy_sum_kept", sum, 4'b0010);
        @(posedge clk);                   // re-sampled in IDLE
        #1;
        start = 1'b0;
        chk("busy_accept2", busy, 1'b1);
        wait_done(edges);
        chk("busy_latency2", edges, N);
        chk("busy_sum2", sum, 4'b1110);
        chk("busy_cout2", carry_out, 1'b1);
        chk("busy_ovf2", overflow, 1'b0);
        repeat (2) @(posedge clk);

        // Mid-operation reset between E2 and E3.
        @(negedge clk);
        a = 4'b0110; b = 4'b0011; op = 1'b0; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);                   // E0
        #1 start = 1'b0;
        repeat (2) @(posedge clk);        // E1, E2
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_sum", sum, 4'b0000);
        chk("mrst_done", done, 1'b0);
        chk("mrst_state", dbg_state, 2'd0);
        saw_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        chk("mrst_no_done", saw_done, 0);
        chk("mrst_still_idle", busy, 1'b0);
        do_op("post_rst", 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
